debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  Multi-channel button debouncer; parametrised successor to the single-input debouncer.
//  Per channel: 2-flop synchroniser, stability counter, debounced level, 1-cycle press/release pulses.
//  Shared prescaler sets the debounce time base. Sits between raw board buttons/coin switches and the FSM.
// PARAMETERS
//  CH         4     number of independent channels
//  CNT_W      16    width of per-channel stability counter
//  STABLE_CNT 50000 ticks of steady disagreement needed to accept a new level (1..2^CNT_W-1)
//  PRESCALE   38    clk cycles per tick (1 = tick every cycle); prescaler width $clog2(PRESCALE)+1
//  INIT_LVL   1'b0  reset level of synchronisers and db_out (all channels)
//  LONG_CNT   1000  ticks db_out must stay 1 before long_p fires (LONG_PRESS_EN only)
// PORTS
//  clk        in   1    system clock
//  n_reset    in   1    reset; one clock, asynchronous, active-high (port name kept, polarity is high)
//  button_in  in   CH   raw asynchronous inputs
//  db_out     out  CH   debounced levels
//  rise_p     out  CH   1-cycle pulse when db_out[i] goes 0->1
//  fall_p     out  CH   1-cycle pulse when db_out[i] goes 1->0
//  long_p     out  CH   1-cycle long-press pulse (driven 0 when LONG_PRESS_EN undefined)
// BEHAVIOUR
//  - Reset (async assert, all regs): sync flops = INIT_LVL, db_out = {CH{INIT_LVL}}, counters 0,
//    prescaler 0, rise_p/fall_p/long_p = 0. Deassertion: first active edge is the next posedge clk.
//  - Sync: s1<=button_in; s2<=s1 every clk (not tick-gated). s2 is the only input the counter sees.
//  - Prescaler: counts 0..PRESCALE-1, wraps; tick=1 for the one clk where count==PRESCALE-1.
//    PRESCALE==1 -> tick constantly 1.
//  - Per channel, each clk:
//    s2==db_out            -> cnt<=0 (regardless of tick) - any glitch back restarts the count.
//    s2!=db_out, !tick     -> cnt holds.
//    s2!=db_out, tick, cnt<STABLE_CNT-1 -> cnt<=cnt+1.
//    s2!=db_out, tick, cnt==STABLE_CNT-1 -> db_out<=s2, cnt<=0, rise_p or fall_p <=1 for that cycle.
//  - rise_p/fall_p are registered, high exactly one clk, never both; cleared every other cycle.
//  - Latency (PRESCALE=1): a raw level held steady changes db_out 2+STABLE_CNT clks after the
//    change; a pulse on button_in shorter than STABLE_CNT clks never changes db_out.
//  - Counter never wraps: max value STABLE_CNT-1, STABLE_CNT must be < 2^CNT_W (elaboration check).
//  - Channels fully independent; simultaneous events on several channels all produce pulses same cycle.
//  - Reset mid-count: count lost, no pulse emitted, db_out returns to INIT_LVL without rise/fall pulse.
// CONFIGURATION
//  LONG_PRESS_EN defined: per-channel hold counter (width $clog2(LONG_CNT)+1), cleared while
//    db_out==0; increments on tick while db_out==1, saturates at LONG_CNT. long_p=1 for one clk on the
//    tick where counter reaches LONG_CNT; exactly one long_p per press, none after release/re-press
//    until counter restarts from 0. Reset clears hold counters.
//  LONG_PRESS_EN undefined: no hold counters synthesised, long_p tied 0.
// TESTING
//  1 Reset: n_reset=1 mid-cycle -> all outputs 0 immediately (async), stay 0 for 5 clks after release.
//  2 PRESCALE=1, STABLE_CNT=8: button_in[0] 0->1 held -> db_out[0]=1 and rise_p[0]=1 exactly 10 clks
//    later, rise_p[0] low next clk; release -> fall_p[0] after 10 clks.
//  3 Glitch: button_in[1] high 7 clks then low (STABLE_CNT=8) -> db_out[1], rise_p[1] never change.
//  4 Bounce: toggle button_in[2] every 3 clks for 30 clks then hold 1 -> single rise_p[2],
//    10 clks after final edge.
//  5 PRESCALE=4, STABLE_CNT=8: hold button_in[3]=1 -> db_out[3] rises within 2+32..2+35 clks;
//    simultaneous press on ch0 and ch3 -> both rise_p in same cycle.
//  6 LONG_PRESS_EN, LONG_CNT=20, PRESCALE=1: hold 100 clks -> one long_p 20 clks after rise_p;
//    reset asserted during hold -> no long_p, no fall_p.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel 2-flop synchroniser, tick-gated stability counter,
// debounced level and 1-cycle rise/fall pulses. Define LONG_PRESS_EN to add long-press pulses.
module debounce_multi #(
  parameter int   CH         = 4,
  parameter int   CNT_W      = 16,
  parameter int   STABLE_CNT = 50000,
  parameter int   PRESCALE   = 38,
  parameter logic INIT_LVL   = 1'b0,
  parameter int   LONG_CNT   = 1000
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic [CH-1:0] button_in,
  output logic [CH-1:0] db_out,
  output logic [CH-1:0] rise_p,
  output logic [CH-1:0] fall_p,
  output logic [CH-1:0] long_p
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  if (STABLE_CNT < 1 || STABLE_CNT >= (1 << CNT_W)) begin : g_bad_stable
    $error("debounce_multi: STABLE_CNT must be in 1..2^CNT_W-1");
  end
  if (PRESCALE < 1 || LONG_CNT < 1) begin : g_bad_scale
    $error("debounce_multi: PRESCALE and LONG_CNT must be >= 1");
  end

  logic tick;

  generate
    if (PRESCALE == 1) begin : g_no_pre
      assign tick = 1'b1;
    end else begin : g_pre
      localparam int PRE_W = $clog2(PRESCALE) + 1;
      localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
      logic [PRE_W-1:0] pre_reg;

      always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
          pre_reg <= '0;
        end else if (pre_reg == PRE_MAX) begin
          pre_reg <= '0;
        end else begin
          pre_reg <= pre_reg + PRE_W'(1);
        end
      end

      assign tick = (pre_reg == PRE_MAX);
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic             s1_reg, s2_reg, db_reg, rise_reg, fall_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
          s1_reg   <= INIT_LVL;
          s2_reg   <= INIT_LVL;
          db_reg   <= INIT_LVL;
          cnt_reg  <= '0;
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          s1_reg   <= button_in[gi];
          s2_reg   <= s1_reg;
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          // Any sample agreeing with the current level restarts the stability window.
          if (s2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (tick) begin
            if (cnt_reg == CNT_MAX) begin
              db_reg   <= s2_reg;
              cnt_reg  <= '0;
              rise_reg <= s2_reg;
              fall_reg <= ~s2_reg;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
      end

      assign db_out[gi] = db_reg;
      assign rise_p[gi] = rise_reg;
      assign fall_p[gi] = fall_reg;

`ifdef LONG_PRESS_EN
      localparam int HOLD_W = $clog2(LONG_CNT) + 1;
      localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CNT);
      localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CNT - 1);
      logic [HOLD_W-1:0] hold_reg;
      logic              long_reg;

      // Saturating at HOLD_MAX guarantees a single long pulse per press.
      always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
          hold_reg <= '0;
          long_reg <= 1'b0;
        end else begin
          long_reg <= 1'b0;
          if (!db_reg) begin
            hold_reg <= '0;
          end else if (tick && hold_reg != HOLD_MAX) begin
            hold_reg <= hold_reg + HOLD_W'(1);
            long_reg <= (hold_reg == HOLD_PRE);
          end
        end
      end

      assign long_p[gi] = long_reg;
`else
      assign long_p[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised scoreboard bench for debounce_multi: two instances (prescale 1 and 4) share the
// stimulus; a history-based reference model predicts pulses that a negedge monitor checks.
module tb_debounce_multi;

  localparam int CH   = 4;
  localparam int STB  = 8;
  localparam int LNG  = 20;
  localparam int MAXC = 32768;
  localparam int PRE [2] = '{1, 4};
`ifdef LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  typedef struct {
    int          d;
    int          cyc;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  lng;
    logic [3:0]  db;
  } ev_t;

  logic          clk = 1'b0;
  logic          n_reset = 1'b1;
  logic [CH-1:0] button_in = '0;
  logic [CH-1:0] db_a, rise_a, fall_a, long_a;
  logic [CH-1:0] db_b, rise_b, fall_b, long_b;

  int compared = 0;
  int mismatched = 0;

  ev_t        evq [$];
  logic [3:0] raw_hist [MAXC];
  int         cyc_now = 0;
  logic [3:0] mdb [2];
  int         last_flip [2][CH];
  int         rise_at [2][CH];

  always #5 clk = ~clk;

  debounce_multi #(.CH(CH), .CNT_W(16), .STABLE_CNT(STB), .PRESCALE(1),
                   .INIT_LVL(1'b0), .LONG_CNT(LNG)) dut_a (
    .clk(clk), .n_reset(n_reset), .button_in(button_in),
    .db_out(db_a), .rise_p(rise_a), .fall_p(fall_a), .long_p(long_a));

  debounce_multi #(.CH(CH), .CNT_W(4), .STABLE_CNT(STB), .PRESCALE(4),
                   .INIT_LVL(1'b0), .LONG_CNT(LNG)) dut_b (
    .clk(clk), .n_reset(n_reset), .button_in(button_in),
    .db_out(db_b), .rise_p(rise_b), .fall_p(fall_b), .long_p(long_b));

  function automatic logic [3:0] raw_at(input int k);
    if (k >= 1) return raw_hist[k];
    return 4'b0000;
  endfunction

  // Reference model: a level is accepted once the input seen two clocks late has disagreed
  // with it for STB consecutive ticks since the last change; long press counts ticks since rise.
  initial forever begin
    @(posedge clk);
    if (n_reset) begin
      cyc_now = 0;
      evq.delete();
      for (int d = 0; d < 2; d++) begin
        mdb[d] = '0;
        for (int i = 0; i < CH; i++) begin
          last_flip[d][i] = 0;
          rise_at[d][i]   = 0;
        end
      end
    end else begin
      cyc_now = cyc_now + 1;
      raw_hist[cyc_now] = button_in;
      for (int d = 0; d < 2; d++) begin
        ev_t        e;
        logic [3:0] seen, newdb;
        int         p;
        bit         tk;
        p    = PRE[d];
        tk   = (cyc_now % p) == 0;
        seen = raw_at(cyc_now - 2);
        e.d = d; e.cyc = cyc_now; e.rise = '0; e.fall = '0; e.lng = '0;
        newdb = mdb[d];
        for (int i = 0; i < CH; i++) begin
          logic db;
          db = mdb[d][i];
          if (LONG_ON && db && tk && ((cyc_now / p) - (rise_at[d][i] / p)) == LNG)
            e.lng[i] = 1'b1;
          if (tk && seen[i] != db) begin
            int cnt;
            cnt = 0;
            for (int k = cyc_now; k > last_flip[d][i]; k--) begin
              logic [3:0] r;
              r = raw_at(k - 2);
              if (r[i] == db) break;
              if (k % p == 0) cnt++;
            end
            if (cnt == STB) begin
              newdb[i] = seen[i];
              last_flip[d][i] = cyc_now;
              if (seen[i]) begin
                e.rise[i] = 1'b1;
                rise_at[d][i] = cyc_now;
              end else begin
                e.fall[i] = 1'b1;
              end
            end
          end
        end
        mdb[d] = newdb;
        e.db = newdb;
        if ((e.rise | e.fall | e.lng) != 4'b0000) evq.push_back(e);
      end
    end
  end

  // Monitor: pops the expected record whenever one is due and flags unexpected pulses.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [3:0] r, f, l, db;
      r  = (d == 0) ? rise_a : rise_b;
      f  = (d == 0) ? fall_a : fall_b;
      l  = (d == 0) ? long_a : long_b;
      db = (d == 0) ? db_a   : db_b;
      if (evq.size() > 0 && evq[0].d == d && evq[0].cyc == cyc_now) begin
        ev_t e;
        e = evq.pop_front();
        compared++;
        if (r !== e.rise || f !== e.fall || l !== e.lng || db !== e.db) begin
          mismatched++;
          $display("FAIL event dut%0d cyc %0d: got rise=%b fall=%b long=%b db=%b, want rise=%b fall=%b long=%b db=%b",
                   d, cyc_now, r, f, l, db, e.rise, e.fall, e.lng, e.db);
        end else begin
          $display("event dut%0d cyc %0d rise=%b fall=%b long=%b db=%b", d, cyc_now, r, f, l, db);
        end
      end else if ((r | f | l) != 4'b0000) begin
        compared++;
        mismatched++;
        $display("FAIL spurious dut%0d cyc %0d: got rise=%b fall=%b long=%b, want none", d, cyc_now, r, f, l);
      end
      compared++;
      if (db !== mdb[d]) begin
        mismatched++;
        $display("FAIL level dut%0d cyc %0d: got db=%b, want db=%b", d, cyc_now, db, mdb[d]);
      end
    end
  end

  task automatic check_zero(input string name);
    logic [31:0] all;
    all = {db_a, rise_a, fall_a, long_a, db_b, rise_b, fall_b, long_b};
    compared++;
    if (all !== '0) begin
      mismatched++;
      $display("FAIL %s: got outputs %h, want 0", name, all);
    end else begin
      $display("check %s outputs all zero", name);
    end
  endtask

  // Called at 1 time unit after a rising edge; leaves v on the inputs for n edges.
  task automatic drive(input logic [3:0] v, input int n);
    button_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asserts reset between negedge and posedge so no due pulse is in flight.
  task automatic mid_reset(input string name);
    #5;
    n_reset = 1'b1;
    #1;
    check_zero(name);
    @(posedge clk);
    #1;
    n_reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_hold");
    n_reset = 1'b0;
    drive(4'b0000, 5);

    drive(4'b0001, 45);
    drive(4'b0000, 45);
    drive(4'b0010, 7);
    drive(4'b0000, 45);
    for (int t = 0; t < 10; t++) drive((t % 2 == 0) ? 4'b0100 : 4'b0000, 3);
    drive(4'b0100, 45);
    drive(4'b0000, 45);
    drive(4'b1001, 45);
    drive(4'b0000, 45);

    drive(4'b0001, 45);
    button_in = 4'b0000;
    mid_reset("async_reset_mid_cycle");
    drive(4'b0000, 5);

    drive(4'b0001, 130);
    drive(4'b0000, 45);
    drive(4'b0001, 25);
    mid_reset("reset_during_hold");
    drive(4'b0000, 45);

    for (int s = 0; s < 110; s++) begin
      logic [3:0] flip;
      int         len;
      flip = 4'($urandom_range(0, 15));
      len  = (s % 10 == 9) ? 140 : $urandom_range(1, 45);
      drive(button_in ^ flip, len);
    end
    drive(4'b0000, 60);

    compared++;
    if (evq.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_events: got %0d pending, want 0", evq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
